// File: rtl/prog_delay_sr.sv
// ---------------------------------------------------------------------------
// prog_delay_sr
//
// Run-time programmable delay line. It delays a data/valid stream by
// 1..MAX_DLY advance cycles so the stream lines up with a slower parallel
// path. Each stage tracks its own valid bit. A stall input holds every stage.
// A flush, either explicit or caused by a change of the requested delay,
// clears the stage valids and restarts the fill tracking. A snapshot of every
// stage is exported for debug.
//
// Parameters
//   DSIZE    data width in bits (>=1)
//   MAX_DLY  number of physical stages, largest selectable delay (>=2)
//   INIT_DLY active delay after reset (1..MAX_DLY)
//   DLY_W    width of the delay select / active delay
//
// Ports
//   clk      in   clock, all logic on the rising edge
//   rst      in   synchronous reset, active-high
//   en       in   advance enable; 0 holds all stages (stall)
//   flush    in   clear all stage valids, restart fill
//   din      in   input data
//   din_vld  in   input data valid
//   dly_sel  in   requested delay in advance cycles (0 -> 1, >MAX_DLY -> MAX_DLY)
//   dout     out  data at the active tap (stage cur_dly-1)
//   dout_vld out  valid at the active tap
//   primed   out  tap holds post-flush content (fill complete)
//   cur_dly  out  active (clamped) delay
//   pdout    out  raw data of all stages, stage 0 in the LSBs
//
// dout, dout_vld, primed and cur_dly are taken only from flops. No input
// reaches them combinationally.
// ---------------------------------------------------------------------------
module prog_delay_sr #(
  parameter int DSIZE    = 8,
  parameter int MAX_DLY  = 16,
  parameter int INIT_DLY = 4,
  parameter int DLY_W    = $clog2(MAX_DLY + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       flush,
  input  logic [DSIZE-1:0]           din,
  input  logic                       din_vld,
  input  logic [DLY_W-1:0]           dly_sel,
  output logic [DSIZE-1:0]           dout,
  output logic                       dout_vld,
  output logic                       primed,
  output logic [DLY_W-1:0]           cur_dly,
  output logic [MAX_DLY*DSIZE-1:0]   pdout
);

  // Fill-status states
  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_PRIMED = 2'd2;

  // Stage storage
  logic [DSIZE-1:0]   stg_data_q [MAX_DLY];
  logic [DSIZE-1:0]   stg_data_d [MAX_DLY];
  logic [MAX_DLY-1:0] stg_vld_q;
  logic [MAX_DLY-1:0] stg_vld_d;

  // Control state
  logic [DLY_W-1:0]   cur_dly_q;
  logic [DLY_W-1:0]   cur_dly_d;
  logic [DLY_W-1:0]   fill_cnt_q;
  logic [DLY_W-1:0]   fill_cnt_d;
  logic [1:0]         state_q;
  logic [1:0]         state_d;

  // Derived control
  logic [DLY_W-1:0]   req_dly_s;
  logic               dly_chg_s;
  logic               flush_ev_s;

  // Clamp the requested delay into the legal range 1..MAX_DLY
  always_comb begin
    req_dly_s = dly_sel;
    if (dly_sel == DLY_W'(0)) begin
      req_dly_s = DLY_W'(1);
    end else if (dly_sel > DLY_W'(MAX_DLY)) begin
      req_dly_s = DLY_W'(MAX_DLY);
    end else begin
      req_dly_s = dly_sel;
    end
  end

  // A change of delay behaves exactly like an explicit flush, even while stalled
  always_comb begin
    dly_chg_s  = (req_dly_s != cur_dly_q);
    flush_ev_s = flush | dly_chg_s;
  end

  // Next-state for stages, active delay and fill-status FSM
  always_comb begin
    stg_data_d = stg_data_q;
    stg_vld_d  = stg_vld_q;
    cur_dly_d  = cur_dly_q;
    fill_cnt_d = fill_cnt_q;
    state_d    = state_q;

    if (flush_ev_s) begin
      // Flush wins over advance: din is dropped and stage data is left as is,
      // only the valids are cleared so stale data can never exit as valid.
      stg_vld_d  = '0;
      cur_dly_d  = req_dly_s;
      fill_cnt_d = DLY_W'(0);
      state_d    = ST_EMPTY;
    end else if (en) begin
      stg_data_d[0] = din;
      for (int i = 1; i < MAX_DLY; i++) begin
        stg_data_d[i] = stg_data_q[i-1];
      end
      stg_vld_d = {stg_vld_q[MAX_DLY-2:0], din_vld};

      // Bubbles count toward filling: the FSM tracks advance edges only
      case (state_q)
        ST_EMPTY: begin
          if (cur_dly_q == DLY_W'(1)) begin
            state_d    = ST_PRIMED;
            fill_cnt_d = cur_dly_q;
          end else begin
            state_d    = ST_FILL;
            fill_cnt_d = DLY_W'(1);
          end
        end
        ST_FILL: begin
          fill_cnt_d = fill_cnt_q + DLY_W'(1);
          if ((fill_cnt_q + DLY_W'(1)) == cur_dly_q) begin
            state_d = ST_PRIMED;
          end else begin
            state_d = ST_FILL;
          end
        end
        ST_PRIMED: begin
          // Saturated: the counter sits at the active delay
          state_d    = ST_PRIMED;
          fill_cnt_d = cur_dly_q;
        end
        default: begin
          // Unreachable encoding: recover through a clean restart
          state_d    = ST_EMPTY;
          fill_cnt_d = DLY_W'(0);
          stg_vld_d  = '0;
        end
      endcase
    end else begin
      // Stall: everything holds (defaults above)
      state_d = state_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_DLY; i++) begin
        stg_data_q[i] <= '0;
      end
      stg_vld_q  <= '0;
      cur_dly_q  <= DLY_W'(INIT_DLY);
      fill_cnt_q <= DLY_W'(0);
      state_q    <= ST_EMPTY;
    end else begin
      stg_data_q <= stg_data_d;
      stg_vld_q  <= stg_vld_d;
      cur_dly_q  <= cur_dly_d;
      fill_cnt_q <= fill_cnt_d;
      state_q    <= state_d;
    end
  end

  // Output tap: one-hot compare against the active delay keeps the mux
  // index free of width juggling; cur_dly_q is always in 1..MAX_DLY.
  always_comb begin
    dout     = '0;
    dout_vld = 1'b0;
    for (int i = 0; i < MAX_DLY; i++) begin
      if (cur_dly_q == DLY_W'(i + 1)) begin
        dout     = stg_data_q[i];
        dout_vld = stg_vld_q[i];
      end else begin
        dout     = dout;
        dout_vld = dout_vld;
      end
    end
  end

  // Status outputs and raw stage snapshot
  always_comb begin
    primed  = (state_q == ST_PRIMED);
    cur_dly = cur_dly_q;
    pdout   = '0;
    for (int i = 0; i < MAX_DLY; i++) begin
      pdout[i*DSIZE +: DSIZE] = stg_data_q[i];
    end
  end

endmodule

// File: tb/tb_prog_delay_sr.sv
module tb_prog_delay_sr;

  localparam int DSIZE    = 8;
  localparam int MAX_DLY  = 8;
  localparam int INIT_DLY = 4;
  localparam int DLY_W    = $clog2(MAX_DLY + 1);

  logic                     clk;
  logic                     rst;
  logic                     en;
  logic                     flush;
  logic [DSIZE-1:0]         din;
  logic                     din_vld;
  logic [DLY_W-1:0]         dly_sel;
  logic [DSIZE-1:0]         dout;
  logic                     dout_vld;
  logic                     primed;
  logic [DLY_W-1:0]         cur_dly;
  logic [MAX_DLY*DSIZE-1:0] pdout;

  int checks = 0;
  int errors = 0;

  prog_delay_sr #(
    .DSIZE   (DSIZE),
    .MAX_DLY (MAX_DLY),
    .INIT_DLY(INIT_DLY),
    .DLY_W   (DLY_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .flush   (flush),
    .din     (din),
    .din_vld (din_vld),
    .dly_sel (dly_sel),
    .dout    (dout),
    .dout_vld(dout_vld),
    .primed  (primed),
    .cur_dly (cur_dly),
    .pdout   (pdout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one rising edge, then settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic v);
    din     = d;
    din_vld = v;
    step();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0;
    din = 8'hAA; din_vld = 1'b1; dly_sel = 4'd4;

    // Reset / idle
    step(); step();
    chk("rst_dout", 64'(dout), 64'h0);
    chk("rst_vld", 64'(dout_vld), 64'h0);
    chk("rst_primed", 64'(primed), 64'h0);
    chk("rst_cur_dly", 64'(cur_dly), 64'd4);
    chk("rst_pdout", pdout, 64'h0);

    // Basic delay of 4, samples 0x01..0x08
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      drive(8'(k), 1'b1);
      if (k < 4) begin
        chk("fill_vld", 64'(dout_vld), 64'h0);
        chk("fill_primed", 64'(primed), 64'h0);
      end else begin
        chk("basic_dout", 64'(dout), 64'(k - 3));
        chk("basic_vld", 64'(dout_vld), 64'h1);
        chk("basic_primed", 64'(primed), 64'h1);
      end
    end
    chk("basic_pdout", pdout, 64'h0102030405060708);

    // Stall for 3 clocks
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(8'hFF, 1'b1);
      chk("stall_dout", 64'(dout), 64'h05);
      chk("stall_vld", 64'(dout_vld), 64'h1);
      chk("stall_pdout", pdout, 64'h0102030405060708);
    end
    en = 1'b1;
    for (int k = 9; k <= 12; k++) begin
      drive(8'(k), 1'b1);
      chk("resume_dout", 64'(dout), 64'(k - 3));
      chk("resume_vld", 64'(dout_vld), 64'h1);
    end

    // Delay change 4 -> 7: implicit flush, din dropped
    dly_sel = 4'd7;
    drive(8'h0D, 1'b1);
    chk("chg_cur_dly", 64'(cur_dly), 64'd7);
    chk("chg_vld", 64'(dout_vld), 64'h0);
    chk("chg_primed", 64'(primed), 64'h0);
    chk("chg_pdout", pdout, 64'h05060708090A0B0C);
    for (int j = 1; j <= 7; j++) begin
      drive(8'(8'h20 + j), 1'b1);
      chk("chg7_vld", 64'(dout_vld), 64'(j == 7));
      chk("chg7_primed", 64'(primed), 64'(j == 7));
    end
    chk("chg7_dout", 64'(dout), 64'h21);

    // Clamp: dly_sel=0 -> 1
    dly_sel = 4'd0;
    drive(8'h30, 1'b1);
    chk("clamp0_cur_dly", 64'(cur_dly), 64'd1);
    chk("clamp0_vld", 64'(dout_vld), 64'h0);
    chk("clamp0_primed", 64'(primed), 64'h0);
    drive(8'h31, 1'b1);
    chk("clamp0_dout", 64'(dout), 64'h31);
    chk("clamp0_vld1", 64'(dout_vld), 64'h1);
    chk("clamp0_primed1", 64'(primed), 64'h1);
    // Bubble at delay 1
    drive(8'h32, 1'b0);
    chk("bubble_dout", 64'(dout), 64'h32);
    chk("bubble_vld", 64'(dout_vld), 64'h0);
    chk("bubble_primed", 64'(primed), 64'h1);

    // Clamp: dly_sel=15 -> 8, applied while stalled
    dly_sel = 4'd15;
    en = 1'b0;
    drive(8'h33, 1'b1);
    chk("clamp15_cur_dly", 64'(cur_dly), 64'd8);
    chk("clamp15_primed", 64'(primed), 64'h0);
    chk("clamp15_stg0", 64'(pdout[7:0]), 64'h32);
    en = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      drive(8'(8'h40 + j), 1'b1);
      chk("max_vld", 64'(dout_vld), 64'(j == 8));
      chk("max_primed", 64'(primed), 64'(j == 8));
    end
    chk("max_dout", 64'(dout), 64'h41);
    chk("max_stg7", 64'(pdout[63:56]), 64'h41);

    // Flush together with en and a valid 0x5A
    flush = 1'b1;
    drive(8'h5A, 1'b1);
    flush = 1'b0;
    chk("flush_vld", 64'(dout_vld), 64'h0);
    chk("flush_primed", 64'(primed), 64'h0);
    chk("flush_stg0", 64'(pdout[7:0]), 64'h48);
    chk("flush_stg7", 64'(pdout[63:56]), 64'h41);
    for (int j = 0; j < 8; j++) begin
      drive(8'(8'h60 + j), 1'b1);
      chk("refill_vld", 64'(dout_vld), 64'(j == 7));
      chk("refill_primed", 64'(primed), 64'(j == 7));
    end
    chk("refill_dout", 64'(dout), 64'h60);

    // Reset in the middle of a fill
    flush = 1'b1;
    drive(8'h70, 1'b1);
    flush = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      drive(8'(8'h70 + j), 1'b1);
    end
    chk("midfill_primed", 64'(primed), 64'h0);
    rst = 1'b1;
    dly_sel = 4'd2;
    drive(8'h7F, 1'b1);
    chk("midrst_dout", 64'(dout), 64'h0);
    chk("midrst_vld", 64'(dout_vld), 64'h0);
    chk("midrst_primed", 64'(primed), 64'h0);
    chk("midrst_cur_dly", 64'(cur_dly), 64'd4);
    chk("midrst_pdout", pdout, 64'h0);
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
